systolic_feeder: RTL and testbench
==================================

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width (fp16: EXP_BITS 5, FRAC_BITS 10).
REQ-002 SHALL have parameter ARR_HEIGHT, default 4, number of array rows (west lanes).
REQ-003 SHALL have parameter ARR_WIDTH, default 4, number of array columns (north lanes).
REQ-004 SHALL have parameter K_BITS, default 16, width of the tile depth count.
REQ-005 SHALL have port clk, input, 1, the only clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, one-cycle tile start request.
REQ-008 SHALL have port k_len, input, K_BITS, number of k-beats in the tile, sampled with start.
REQ-009 SHALL have port in_valid, input, 1, a_vec/b_vec carry a valid beat.
REQ-010 SHALL have port in_ready, output, 1, feeder accepts a beat this cycle.
REQ-011 SHALL have port a_vec, input, ARR_HEIGHT*WIDTH, one A column slice; lane i = bits [(i+1)*WIDTH-1 : i*WIDTH].
REQ-012 SHALL have port b_vec, input, ARR_WIDTH*WIDTH, one B row slice; lane j packed the same way.
REQ-013 SHALL have port out_a, output, ARR_HEIGHT*WIDTH, skewed west stream, drives the array's in_a.
REQ-014 SHALL have port out_b, output, ARR_WIDTH*WIDTH, skewed north stream, drives the array's in_b.
REQ-015 SHALL have port arr_clear, output, 1, one-cycle accumulator-clear pulse for the array's reset.
REQ-016 SHALL have ports busy and done, output, 1 each: busy high outside IDLE; done is a one-cycle completion pulse.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, FEED, FLUSH, DONE.
REQ-018 IDLE->CLEAR on start; start SHALL be ignored in every other state.
REQ-019 CLEAR SHALL last exactly 1 cycle with arr_clear=1, then go to FEED, or to DONE if the latched k_len==0.
REQ-020 In FEED, in_ready SHALL be 1; a beat is accepted when in_valid&&in_ready; the accepted-beat counter increments by 1 per beat.
REQ-021 FEED SHALL go to FLUSH in the cycle after the k_len-th beat is accepted; in_ready SHALL be 0 outside FEED.
REQ-022 Skew: lane i of out_a SHALL equal a_vec lane i of a beat accepted in cycle t, appearing in cycle t+1+i; lane j of out_b likewise, appearing in cycle t+1+j.
REQ-023 A cycle with no accepted beat (bubble, or any non-FEED state) SHALL inject 16'h0000 (fp zero) at the head of every skew lane.
REQ-024 FLUSH SHALL last exactly ARR_HEIGHT+ARR_WIDTH-1 cycles of zero injection, counted by a down-counter, then go to DONE.
REQ-025 DONE SHALL last 1 cycle with done=1, then go to IDLE.
REQ-026 Output bit patterns SHALL pass through unmodified; no arithmetic on operands.
REQ-027 k_len SHALL be treated as unsigned; k_len = 2^K_BITS-1 SHALL work without counter overflow.

Reset
REQ-028 reset SHALL force IDLE and clear every skew register, the beat counter, and the flush counter to 0 in the same clock edge.
REQ-029 While reset is asserted or in the cycle after release: out_a=0, out_b=0, in_ready=0, busy=0, done=0, arr_clear=0.
REQ-030 reset during any state SHALL abort the tile without a done pulse; a partially fed tile SHALL be discarded.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, the fp16 zero constant, and the default WIDTH/ARR_HEIGHT/ARR_WIDTH values.
REQ-032 The per-lane delay line SHALL be one sub-module, skew_delay (parameters WIDTH, DEPTH), instantiated once per lane with DEPTH = lane index + 1.

Verification
REQ-033 Reset with X inputs -> all outputs 0 in the next cycle; start held during reset -> no state change.
REQ-034 4x4, k_len=1, a_vec lanes 0x3C00/0x4000/0x4200/0x4400, beat accepted at cycle T -> out_a lane i = that value only in cycle T+1+i, else 0; done exactly 1 pulse at T+1+7+1.
REQ-035 k_len=3 with one bubble (in_valid=0 at 2nd FEED cycle) -> zero column inserted in every lane; 3 beats counted; FLUSH entered only after the 3rd beat.
REQ-036 k_len=0 -> arr_clear at cycle S+1, done at S+2, no in_ready assertion.
REQ-037 start pulsed during FEED and FLUSH -> ignored; tile finishes with a single done.
REQ-038 reset asserted mid-FEED after 2 of 4 beats -> IDLE, skew lanes 0, no done; a new start then runs a full tile correctly.

Source files
------------

// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic array operand feeder: FSM state
// encoding, the fp16 zero pattern injected into idle skew lanes, and the
// default geometry of the array being fed.
package systolic_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } feeder_state_t;

  // Positive fp16 zero; pushed into every skew lane on cycles without a beat.
  localparam logic [15:0] FP16_ZERO = 16'h0000;

  localparam int DEFAULT_WIDTH      = 16;
  localparam int DEFAULT_ARR_HEIGHT = 4;
  localparam int DEFAULT_ARR_WIDTH  = 4;

endpackage : systolic_feeder_pkg

// File: rtl/systolic_feeder_skew_delay.sv
// Fixed-length delay line for one operand lane. Lane n of the feeder uses
// DEPTH = n + 1 so that successive lanes reach the array one cycle apart,
// producing the diagonal wavefront a systolic array expects.
module skew_delay #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_reg [DEPTH];

  // Shift the lane by one stage per cycle; reset empties the whole line.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_reg[s] <= '0;
      end
    end else begin
      stage_reg[0] <= din;
      for (int s = 1; s < DEPTH; s++) begin
        stage_reg[s] <= stage_reg[s-1];
      end
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule : skew_delay

// File: rtl/systolic_feeder.sv
// Operand feeder for an ARR_HEIGHT x ARR_WIDTH systolic array. For each
// tile it pulses the array's accumulator clear, accepts k_len beats of
// A-column / B-row slices, skews them lane by lane, then flushes zeros long
// enough for the last beat to traverse the array before signalling done.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int ARR_HEIGHT = DEFAULT_ARR_HEIGHT,
  parameter int ARR_WIDTH  = DEFAULT_ARR_WIDTH,
  parameter int K_BITS     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [K_BITS-1:0]           k_len,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ARR_HEIGHT*WIDTH-1:0] a_vec,
  input  logic [ARR_WIDTH*WIDTH-1:0]  b_vec,
  output logic [ARR_HEIGHT*WIDTH-1:0] out_a,
  output logic [ARR_WIDTH*WIDTH-1:0]  out_b,
  output logic                        arr_clear,
  output logic                        busy,
  output logic                        done
);

  // Zero cycles needed after the last beat so it reaches the far corner.
  localparam int FLUSH_LEN  = ARR_HEIGHT + ARR_WIDTH - 1;
  localparam int FLUSH_BITS = $clog2(FLUSH_LEN + 1);
  localparam logic [FLUSH_BITS-1:0] FLUSH_LOAD = FLUSH_BITS'(FLUSH_LEN);
  localparam logic [FLUSH_BITS-1:0] FLUSH_LAST = FLUSH_BITS'(1);
  localparam logic [WIDTH-1:0]      LANE_ZERO  = WIDTH'(FP16_ZERO);

  feeder_state_t           state_reg;
  logic [K_BITS-1:0]       k_len_reg;
  logic [K_BITS-1:0]       beat_cnt_reg;
  logic [FLUSH_BITS-1:0]   flush_cnt_reg;
  logic                    in_ready_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic                    arr_clear_reg;
  logic                    accept;

  // in_ready_reg is only ever high in FEED, so it also gates acceptance.
  assign accept = in_valid && in_ready_reg;

  // Tile sequencing. in_ready drops right after the final beat so the
  // counter can never pass k_len; the following FEED cycle hands over to
  // FLUSH once the counter shows the tile is complete.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      k_len_reg     <= '0;
      beat_cnt_reg  <= '0;
      flush_cnt_reg <= '0;
      in_ready_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      arr_clear_reg <= 1'b0;
    end else begin
      arr_clear_reg <= 1'b0;
      done_reg      <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg     <= ST_CLEAR;
            k_len_reg     <= k_len;
            beat_cnt_reg  <= '0;
            arr_clear_reg <= 1'b1;
            busy_reg      <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (k_len_reg == '0) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end else begin
            state_reg    <= ST_FEED;
            in_ready_reg <= 1'b1;
          end
        end
        ST_FEED: begin
          if (accept) begin
            beat_cnt_reg <= beat_cnt_reg + K_BITS'(1);
            if (beat_cnt_reg + K_BITS'(1) == k_len_reg) begin
              in_ready_reg <= 1'b0;
            end
          end else if (beat_cnt_reg == k_len_reg) begin
            state_reg     <= ST_FLUSH;
            flush_cnt_reg <= FLUSH_LOAD;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_reg == FLUSH_LAST) begin
            state_reg     <= ST_DONE;
            flush_cnt_reg <= '0;
            done_reg      <= 1'b1;
          end else begin
            flush_cnt_reg <= flush_cnt_reg - FLUSH_LAST;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg    <= ST_IDLE;
          in_ready_reg <= 1'b0;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign arr_clear = arr_clear_reg;

  // West lanes: row i of the array sees its A operand i cycles later.
  generate
    for (genvar gi = 0; gi < ARR_HEIGHT; gi++) begin : g_lane_a
      logic [WIDTH-1:0] head;
      assign head = accept ? a_vec[gi*WIDTH +: WIDTH] : LANE_ZERO;
      skew_delay #(
        .WIDTH (WIDTH),
        .DEPTH (gi + 1)
      ) u_skew_a (
        .clk   (clk),
        .reset (reset),
        .din   (head),
        .dout  (out_a[gi*WIDTH +: WIDTH])
      );
    end
  endgenerate

  // North lanes: column j of the array sees its B operand j cycles later.
  generate
    for (genvar gi = 0; gi < ARR_WIDTH; gi++) begin : g_lane_b
      logic [WIDTH-1:0] head;
      assign head = accept ? b_vec[gi*WIDTH +: WIDTH] : LANE_ZERO;
      skew_delay #(
        .WIDTH (WIDTH),
        .DEPTH (gi + 1)
      ) u_skew_b (
        .clk   (clk),
        .reset (reset),
        .din   (head),
        .dout  (out_b[gi*WIDTH +: WIDTH])
      );
    end
  endgenerate

endmodule : systolic_feeder

// File: tb/tb_systolic_feeder.sv
// Randomised scoreboard bench for systolic_feeder. Each tile is planned at
// start time from the protocol rules (clear one cycle after start, feeding
// from the cycle after that, lane n delayed by n+1 cycles, done a fixed
// drain time after the last beat); the plan populates per-cycle expectation
// tables that an independent negedge monitor compares against the outputs.
module tb_systolic_feeder;

  localparam int W  = 16;
  localparam int AH = 4;
  localparam int AW = 4;
  localparam int KB = 16;

  logic              clk;
  logic              reset;
  logic              start;
  logic [KB-1:0]     k_len;
  logic              in_valid;
  logic              in_ready;
  logic [AH*W-1:0]   a_vec;
  logic [AW*W-1:0]   b_vec;
  logic [AH*W-1:0]   out_a;
  logic [AW*W-1:0]   out_b;
  logic              arr_clear;
  logic              busy;
  logic              done;

  systolic_feeder #(
    .WIDTH      (W),
    .ARR_HEIGHT (AH),
    .ARR_WIDTH  (AW),
    .K_BITS     (KB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .k_len     (k_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_vec     (a_vec),
    .b_vec     (b_vec),
    .out_a     (out_a),
    .out_b     (out_b),
    .arr_clear (arr_clear),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle n is the interval following the n-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Expectation tables keyed by cycle; a missing entry means all zero.
  // ctl bits: 3 in_ready, 2 busy, 1 arr_clear, 0 done.
  logic [AH*W-1:0] exp_a   [int];
  logic [AW*W-1:0] exp_b   [int];
  logic [3:0]      exp_ctl [int];
  int              done_q  [$];

  // Per-cycle drive plan for the feed window of the current tile.
  logic            drv_v [int];
  logic [AH*W-1:0] drv_a [int];
  logic [AW*W-1:0] drv_b [int];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endtask

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input int c, input int bitn);
    logic [3:0] t;
    t = exp_ctl.exists(c) ? exp_ctl[c] : 4'b0;
    t[bitn] = 1'b1;
    exp_ctl[c] = t;
  endtask

  task automatic put_a(input int c, input int lane, input logic [W-1:0] v);
    logic [AH*W-1:0] t;
    t = exp_a.exists(c) ? exp_a[c] : '0;
    t[lane*W +: W] = v;
    exp_a[c] = t;
  endtask

  task automatic put_b(input int c, input int lane, input logic [W-1:0] v);
    logic [AW*W-1:0] t;
    t = exp_b.exists(c) ? exp_b[c] : '0;
    t[lane*W +: W] = v;
    exp_b[c] = t;
  endtask

  // A reset sampled at the end of cycle c wipes everything planned later.
  task automatic purge_after(input int c);
    int keys[$];
    keys = {};
    foreach (exp_a[k]) if (k > c) keys.push_back(k);
    foreach (keys[i]) exp_a.delete(keys[i]);
    keys = {};
    foreach (exp_b[k]) if (k > c) keys.push_back(k);
    foreach (keys[i]) exp_b.delete(keys[i]);
    keys = {};
    foreach (exp_ctl[k]) if (k > c) keys.push_back(k);
    foreach (keys[i]) exp_ctl.delete(keys[i]);
    done_q = done_q.find(x) with (x <= c);
  endtask

  task automatic drive_random_idle();
    start    = 1'b0;
    k_len    = KB'($urandom);
    in_valid = 1'($urandom_range(0, 1));
    a_vec    = {$urandom, $urandom};
    b_vec    = {$urandom, $urandom};
  endtask

  // Plan one tile starting in the current cycle, then drive it to done
  // (or to the abort point when abort_beats >= 0).
  task automatic run_tile(input int k, input bit use_pat, input logic [31:0] vpat,
                          input bit fixed_a, input bit extra_starts, input int abort_beats);
    int s, c, beats, last, done_c, abort_c;
    logic v;
    logic [AH*W-1:0] av;
    logic [AW*W-1:0] bv;
    s = cyc;
    beats = 0;
    last = -1;
    abort_c = -1;
    drv_v.delete();
    drv_a.delete();
    drv_b.delete();
    set_ctl(s + 1, 1);
    c = s + 2;
    while (beats < k) begin
      set_ctl(c, 3);
      v  = use_pat ? vpat[(c - s - 2) % 32] : ($urandom_range(0, 9) < 7);
      av = {$urandom, $urandom};
      bv = {$urandom, $urandom};
      if (fixed_a) av = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
      drv_v[c] = v;
      drv_a[c] = av;
      drv_b[c] = bv;
      if (v) begin
        for (int i = 0; i < AH; i++) put_a(c + 1 + i, i, av[i*W +: W]);
        for (int j = 0; j < AW; j++) put_b(c + 1 + j, j, bv[j*W +: W]);
        beats++;
        last = c;
        if (beats == abort_beats) abort_c = c + 1;
      end
      c++;
    end
    done_c = (k == 0) ? s + 2 : last + AH + AW + 1;
    for (int x = s + 1; x <= done_c; x++) set_ctl(x, 2);
    set_ctl(done_c, 0);
    done_q.push_back(done_c);
    $display("tile start=%0d k=%0d beats_planned=%0d expected_done=%0d abort_at=%0d",
             s, k, beats, done_c, abort_c);

    for (int cc = s; cc <= done_c; cc++) begin
      if (abort_c >= 0 && cc == abort_c) begin
        reset    = 1'b1;
        start    = 1'b1;
        in_valid = drv_v.exists(cc) ? drv_v[cc] : 1'b1;
        purge_after(cc);
        wait_cycle();
        wait_cycle();
        reset = 1'b0;
        drive_random_idle();
        wait_cycle();
        return;
      end
      drive_random_idle();
      if (cc == s) begin
        start = 1'b1;
        k_len = KB'(k);
      end else if (extra_starts && (cc == s + 3 || cc == last + 3)) begin
        start = 1'b1;
      end
      if (drv_v.exists(cc)) begin
        in_valid = drv_v[cc];
        a_vec    = drv_a[cc];
        b_vec    = drv_b[cc];
      end
      wait_cycle();
    end
    drive_random_idle();
  endtask

  // Monitor: compare every output each cycle, and match done pulses
  // against the queue of predicted completion cycles.
  logic [AH*W-1:0] m_ea;
  logic [AW*W-1:0] m_eb;
  logic [3:0]      m_ec;
  int              m_dc;
  always @(negedge clk) begin
    if (cyc >= 1) begin
      m_ea = exp_a.exists(cyc)   ? exp_a[cyc]   : '0;
      m_eb = exp_b.exists(cyc)   ? exp_b[cyc]   : '0;
      m_ec = exp_ctl.exists(cyc) ? exp_ctl[cyc] : 4'b0;
      chk("out_a",     128'(out_a),     128'(m_ea));
      chk("out_b",     128'(out_b),     128'(m_eb));
      chk("in_ready",  128'(in_ready),  128'(m_ec[3]));
      chk("busy",      128'(busy),      128'(m_ec[2]));
      chk("arr_clear", 128'(arr_clear), 128'(m_ec[1]));
      chk("done",      128'(done),      128'(m_ec[0]));
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done_unexpected cycle=%0d actual=1 required=0", cyc);
        end else begin
          m_dc = done_q.pop_front();
          chk("done_cycle", 128'(cyc), 128'(m_dc));
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b1;
    k_len    = 'x;
    in_valid = 1'bx;
    a_vec    = 'x;
    b_vec    = 'x;
    repeat (3) wait_cycle();
    reset = 1'b0;
    drive_random_idle();
    wait_cycle();
    wait_cycle();

    // Single beat with the fp16 ramp on the west lanes.
    run_tile(1, 1'b1, 32'h1, 1'b1, 1'b0, -1);
    wait_cycle();
    // Three beats with a bubble in the second feed cycle.
    run_tile(3, 1'b1, 32'hD, 1'b0, 1'b0, -1);
    wait_cycle();
    // Empty tile: clear then done, never ready.
    run_tile(0, 1'b1, 32'h0, 1'b0, 1'b0, -1);
    wait_cycle();
    // Stray starts during FEED and FLUSH must be ignored.
    run_tile(4, 1'b1, 32'hF, 1'b0, 1'b1, -1);
    wait_cycle();
    // Abort after two of four beats, then a clean tile.
    run_tile(4, 1'b1, 32'hF, 1'b0, 1'b0, 2);
    wait_cycle();
    run_tile(4, 1'b0, 32'h0, 1'b0, 1'b0, -1);

    // Randomised tiles with random gaps (including back-to-back starts).
    for (int n = 0; n < 10; n++) begin
      repeat ($urandom_range(0, 3)) begin
        drive_random_idle();
        wait_cycle();
      end
      run_tile($urandom_range(0, 10), 1'b0, 32'h0, 1'b0, 1'($urandom_range(0, 1)), -1);
    end

    repeat (12) begin
      drive_random_idle();
      wait_cycle();
    end
    chk("done_queue_empty", 128'(done_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_systolic_feeder
